uart_rx: RTL and testbench

UART receiver matching the team's configurable UART transmitter: same oversampled tick, 5–8 data bits, optional even/odd parity and programmable stop length. Deserialises the asynchronous rx line into a parallel word and reports parity and framing errors. Sits between the board RX pin and the UART core's receive FIFO; rx_done acts as the FIFO write strobe.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_if.sv | 24 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/uart_rx.sv | 159 +++++++++++++++
 tb/tb_uart_rx.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data-width limits and parity
// polarity encoding common to the transmitter and receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam logic [3:0] MIN_DBITS = 4'd5;
   localparam logic [3:0] MAX_DBITS = 4'd8;

   localparam logic PAR_EVEN = 1'b1;
   localparam logic PAR_ODD  = 1'b0;

   // Out-of-range data widths fall back to a full byte.
   function automatic logic [3:0] norm_dbits(input logic [3:0] d);
      if ((d < MIN_DBITS) || (d > MAX_DBITS)) begin
         return MAX_DBITS;
      end else begin
         return d;
      end
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side result bus from the UART receiver to the receive FIFO;
// rx_done is the FIFO write strobe.
interface uart_rx_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] dout;
   logic                 rx_done;
   logic                 parity_err;
   logic                 frame_err;

   modport master (
      output dout,
      output rx_done,
      output parity_err,
      output frame_err
   );

   modport slave (
      input dout,
      input rx_done,
      input parity_err,
      input frame_err
   );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a
// configurable reset value so idle-high lines come out of reset idle.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] ff_q;

   // Shift the asynchronous input through two flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         ff_q <= {2{RST_VAL}};
      end else begin
         ff_q <= {ff_q[0], d_i};
      end
   end

   assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop deserialiser with
// per-frame configuration latched at the start edge.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int OVRSAMPLING = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        s_tick,
   input  logic        rx,
   input  logic [3:0]  d_bits,
   input  logic [5:0]  stop_ticks,
   input  logic        parity_en,
   input  logic        parity_pol,
   uart_rx_if.master   rx_if
);

   localparam int SW = ($clog2(OVRSAMPLING) > 6) ? $clog2(OVRSAMPLING) : 6;
   localparam int DW = $clog2(DATA_BITS + 1);
   localparam logic [SW-1:0] S_MID  = SW'(OVRSAMPLING / 2 - 1);
   localparam logic [SW-1:0] S_LAST = SW'(OVRSAMPLING - 1);

   logic                 rx_s;
   uart_state_e          state_q;
   logic [SW-1:0]        s_q;
   logic [2:0]           n_q;
   logic [DATA_BITS-1:0] b_q;
   logic                 par_q;
   logic                 par_bad_q;
   logic [3:0]           dbits_q;
   logic [5:0]           stop_q;
   logic                 pen_q;
   logic                 ppol_q;
   logic [DATA_BITS-1:0] dout_q;
   logic                 done_q;
   logic                 perr_q;
   logic                 ferr_q;

   logic [5:0]           stop_m1_s;
   logic                 stop_last_s;
   logic [2:0]           n_last_s;
   logic [DW-1:0]        shamt_s;

   sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (rx),
      .q_o   (rx_s)
   );

   // stop_q=0 wraps to 63 here, giving a 64-tick stop period.
   assign stop_m1_s   = stop_q - 6'd1;
   assign stop_last_s = (s_q == SW'(stop_m1_s));
   assign n_last_s    = 3'(dbits_q - 4'd1);
   assign shamt_s     = DW'(DATA_BITS) - DW'(dbits_q);

   // Receiver FSMD: counters, shift register, latched config and outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         s_q       <= '0;
         n_q       <= 3'd0;
         b_q       <= '0;
         par_q     <= 1'b0;
         par_bad_q <= 1'b0;
         dbits_q   <= MAX_DBITS;
         stop_q    <= 6'd0;
         pen_q     <= 1'b0;
         ppol_q    <= PAR_ODD;
         dout_q    <= '0;
         done_q    <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_q <= START;
                  s_q     <= '0;
                  dbits_q <= norm_dbits(d_bits);
                  stop_q  <= stop_ticks;
                  pen_q   <= parity_en;
                  ppol_q  <= parity_pol;
               end
            end
            START: begin
               if (s_tick) begin
                  if (s_q == S_MID) begin
                     s_q <= '0;
                     if (!rx_s) begin
                        state_q   <= DATA;
                        n_q       <= 3'd0;
                        par_q     <= 1'b0;
                        par_bad_q <= 1'b0;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     s_q <= s_q + SW'(1);
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s_q == S_LAST) begin
                     s_q   <= '0;
                     b_q   <= {rx_s, b_q[DATA_BITS-1:1]};
                     par_q <= par_q ^ rx_s;
                     if (n_q == n_last_s) begin
                        state_q <= pen_q ? PARITY : STOP;
                     end else begin
                        n_q <= n_q + 3'd1;
                     end
                  end else begin
                     s_q <= s_q + SW'(1);
                  end
               end
            end
            PARITY: begin
               if (s_tick) begin
                  if (s_q == S_LAST) begin
                     s_q       <= '0;
                     par_bad_q <= rx_s != (ppol_q ? par_q : ~par_q);
                     state_q   <= STOP;
                  end else begin
                     s_q <= s_q + SW'(1);
                  end
               end
            end
            STOP: begin
               if (s_tick) begin
                  if (stop_last_s) begin
                     state_q <= IDLE;
                     s_q     <= '0;
                     done_q  <= 1'b1;
                     dout_q  <= b_q >> shamt_s;
                     perr_q  <= pen_q & par_bad_q;
                     ferr_q  <= ~rx_s;
                  end else begin
                     s_q <= s_q + SW'(1);
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign rx_if.dout       = dout_q;
   assign rx_if.rx_done    = done_q;
   assign rx_if.parity_err = perr_q;
   assign rx_if.frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a behavioural serial transmitter drives rx
// and a frame-level model predicts word, error flags and completion latency.
module tb_uart_rx;

   localparam int DB   = 8;
   localparam int OS   = 16;
   localparam int TDIV = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       s_tick;
   logic       rx;
   logic [3:0] d_bits;
   logic [5:0] stop_ticks;
   logic       parity_en;
   logic       parity_pol;

   uart_rx_if #(.DATA_BITS(DB)) rx_if ();

   uart_rx #(.DATA_BITS(DB), .OVRSAMPLING(OS)) dut (
      .clk        (clk),
      .reset      (reset),
      .s_tick     (s_tick),
      .rx         (rx),
      .d_bits     (d_bits),
      .stop_ticks (stop_ticks),
      .parity_en  (parity_en),
      .parity_pol (parity_pol),
      .rx_if      (rx_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  dout;
      logic        perr;
      logic        ferr;
      int unsigned tick;
   } frame_t;

   frame_t      q[$];
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned tick_cnt = 0;
   int          div = 0;
   logic [7:0]  last_dout;
   logic        last_perr;
   logic        last_ferr;

   // One-clk tick every TDIV clocks, driven away from the active edge.
   initial begin
      s_tick = 1'b0;
      forever begin
         @(negedge clk);
         s_tick = (div == 0);
         div = (div + 1) % TDIV;
      end
   end

   always @(posedge clk) if (s_tick) tick_cnt <= tick_cnt + 1;

   // Every cycle with rx_done high is recorded, so a long pulse shows up as extra frames.
   always @(negedge clk) begin
      if (rx_if.rx_done === 1'b1) begin
         q.push_back('{dout: rx_if.dout, perr: rx_if.parity_err,
                       ferr: rx_if.frame_err, tick: tick_cnt});
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         while (s_tick !== 1'b1) @(posedge clk);
      end
      #1;
   endtask

   function automatic int eff_bits(input logic [3:0] d);
      return ((d < 4'd5) || (d > 4'd8)) ? 8 : int'(d);
   endfunction

   function automatic int eff_stop(input logic [5:0] s);
      return (s == 6'd0) ? 64 : int'(s);
   endfunction

   // Serialise one frame LSB first; config inputs are scrambled once the start bit is out.
   task automatic send_frame(input logic [7:0] data, input logic [3:0] db, input logic pen,
                             input logic pol, input logic [5:0] st, input logic flip,
                             input logic stop_low, output int unsigned t0);
      int         nb;
      int         se;
      logic [7:0] dm;
      logic       pbit;
      nb = eff_bits(db);
      se = eff_stop(st);
      dm = data & 8'((1 << nb) - 1);
      d_bits = db; stop_ticks = st; parity_en = pen; parity_pol = pol;
      wait_ticks(1);
      t0 = tick_cnt;
      rx = 1'b0;
      wait_ticks(OS);
      d_bits = 4'($urandom); stop_ticks = 6'($urandom);
      parity_en = 1'($urandom); parity_pol = 1'($urandom);
      for (int i = 0; i < nb; i++) begin
         rx = data[i];
         wait_ticks(OS);
      end
      if (pen) begin
         pbit = (pol == 1'b1) ? ($countones(dm) % 2 == 1) : ($countones(dm) % 2 == 0);
         rx = pbit ^ flip;
         wait_ticks(OS);
      end
      if (stop_low) begin
         rx = 1'b0;
         wait_ticks(11);
         rx = 1'b1;
         wait_ticks(se - 11 + 12);
      end else begin
         rx = 1'b1;
         wait_ticks(se);
      end
      wait_ticks(4);
   endtask

   task automatic frame_test(input string tag, input logic [7:0] data, input logic [3:0] db,
                             input logic pen, input logic pol, input logic [5:0] st,
                             input logic flip, input logic stop_low);
      int unsigned t0;
      int          nb;
      logic [7:0]  exp_dout;
      frame_t      f;
      nb = eff_bits(db);
      exp_dout = data & 8'((1 << nb) - 1);
      send_frame(data, db, pen, pol, st, flip, stop_low, t0);
      chk({tag, "_count"}, q.size(), 1);
      if (q.size() > 0) begin
         f = q.pop_front();
         chk({tag, "_dout"}, f.dout, exp_dout);
         chk({tag, "_perr"}, f.perr, pen & flip);
         chk({tag, "_ferr"}, f.ferr, stop_low);
         chk({tag, "_lat"}, f.tick - t0, OS / 2 + OS * (nb + int'(pen)) + eff_stop(st));
      end
      q.delete();
      last_dout = exp_dout; last_perr = pen & flip; last_ferr = stop_low;
   endtask

   initial begin
      frame_t     f;
      logic [5:0] stops [4] = '{6'd16, 6'd24, 6'd32, 6'd0};

      reset = 1'b1; rx = 1'b1;
      d_bits = 4'd8; stop_ticks = 6'd16; parity_en = 1'b0; parity_pol = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dout", rx_if.dout, 0);
      chk("rst_done", rx_if.rx_done, 0);
      chk("rst_perr", rx_if.parity_err, 0);
      chk("rst_ferr", rx_if.frame_err, 0);
      reset = 1'b0;
      wait_ticks(4);

      frame_test("8n1_a5", 8'hA5, 4'd8, 1'b0, 1'b1, 6'd16, 1'b0, 1'b0);
      frame_test("7e1_ok", 8'h35, 4'd7, 1'b1, 1'b1, 6'd16, 1'b0, 1'b0);
      frame_test("7e1_bad", 8'h35, 4'd7, 1'b1, 1'b1, 6'd16, 1'b1, 1'b0);
      frame_test("5o2_1b", 8'h1B, 4'd5, 1'b1, 1'b0, 6'd32, 1'b0, 1'b0);
      frame_test("8n1_stoplow", 8'hC3, 4'd8, 1'b0, 1'b1, 6'd16, 1'b0, 1'b1);

      // Break: 20 bit times low yields two complete all-zero framing-error frames.
      d_bits = 4'd8; stop_ticks = 6'd16; parity_en = 1'b0;
      wait_ticks(1);
      rx = 1'b0;
      wait_ticks(20 * OS);
      chk("break_count", q.size(), 2);
      for (int i = 0; i < 2; i++) begin
         if (q.size() > 0) begin
            f = q.pop_front();
            chk("break_dout", f.dout, 0);
            chk("break_ferr", f.ferr, 1);
            chk("break_perr", f.perr, 0);
         end
      end
      rx = 1'b1;
      wait_ticks(200);
      q.delete();

      frame_test("pre_glitch", 8'h5A, 4'd8, 1'b0, 1'b1, 6'd16, 1'b0, 1'b0);
      wait_ticks(1);
      rx = 1'b0;
      wait_ticks(5);
      rx = 1'b1;
      wait_ticks(30);
      chk("glitch_count", q.size(), 0);
      chk("glitch_dout", rx_if.dout, last_dout);
      chk("glitch_perr", rx_if.parity_err, last_perr);
      chk("glitch_ferr", rx_if.frame_err, last_ferr);
      frame_test("post_glitch", 8'h3C, 4'd8, 1'b0, 1'b1, 6'd16, 1'b0, 1'b0);

      // Reset in the middle of data bit 4 of 0xFF.
      d_bits = 4'd8; stop_ticks = 6'd16; parity_en = 1'b0;
      wait_ticks(1);
      rx = 1'b0;
      wait_ticks(OS);
      rx = 1'b1;
      wait_ticks(4 * OS);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_dout", rx_if.dout, 0);
      chk("midrst_done", rx_if.rx_done, 0);
      chk("midrst_perr", rx_if.parity_err, 0);
      chk("midrst_ferr", rx_if.frame_err, 0);
      reset = 1'b0;
      wait_ticks(5 * OS + 4);
      chk("midrst_count", q.size(), 0);
      q.delete();
      frame_test("after_rst", 8'h81, 4'd8, 1'b0, 1'b1, 6'd16, 1'b0, 1'b0);

      for (int k = 0; k < 12; k++) begin
         frame_test("rnd", 8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom),
                    1'($urandom), stops[$urandom_range(0, 3)], 1'($urandom), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
